multi_cycle_ctrl_fsm: RTL
=========================

MULTI_CYCLE_CTRL_FSM -- requirements
Module: multi_cycle_ctrl_fsm

Interface
REQ-001 Parameter OPW, default 6, opcode width.
REQ-002 Parameter ALUOPW, default 3, ALUOp width.
REQ-003 Parameter CNTW, default 32, retired-instruction counter width.
REQ-004 CLK  input  1  single clock; all state changes on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Opcode  input  OPW  opcode field of the instruction register.
REQ-007 zero, sign  input  1 each  ALU flags, valid in EXE.
REQ-008 mem_ready  input  1  data-memory ready; sampled in MEM.
REQ-009 State  output  3  current state code.
REQ-010 PCWre, IRWre, RegWre, InsMemRW, nRD, nWR, ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc, ExtSel  output  1 each  datapath controls.
REQ-011 RegDst, PCSrc  output  2 each; ALUOp  output  ALUOPW.
REQ-012 halted  output  1  processor stopped on halt.
REQ-013 illegal_op  output  1  sticky flag for an undecoded opcode.
REQ-014 retired  output  CNTW  count of completed instructions.

Function
REQ-015 State codes SHALL be IF=000, ID=001, EXE=010, WB=011, MEM=100, HLT=111.
REQ-016 Transitions: IF->ID always; from ID: j/jr/jal->IF, halt->HLT, undecoded->IF, all others->EXE.
REQ-017 From EXE: beq/bne/bgtz->IF; sw/lw->MEM; add/sub/addi/ori/and/or/sll/slt/slti->WB.
REQ-018 From MEM: hold while mem_ready=0; when mem_ready=1, sw->IF and lw->WB.
REQ-019 WB->IF always; HLT SHALL hold until Reset.
REQ-020 IRWre=1 only in IF; InsMemRW=1 in every state.
REQ-021 PCWre=1 only in an instruction's final state (ID for j/jr/jal/undecoded, EXE for branches, MEM with mem_ready=1 for sw, WB otherwise), so PC updates exactly once per instruction.
REQ-022 RegWre=1 only in WB, and in ID for jal (RegDst=00, WrRegDSrc=0).
REQ-023 nWR=0 only in MEM for sw with mem_ready=1; nRD=0 throughout MEM for lw; both otherwise 1.
REQ-024 PCSrc: 00 sequential; 01 when beq&zero, bne&~zero, or bgtz&~(sign|zero) in EXE; 10 jr; 11 j/jal.
REQ-025 RegDst=10 R-type, 01 I-type ALU; ExtSel=0 for ori, 1 otherwise; ALUSrcA=1 only for sll.
REQ-026 ALUOp: add/addi/lw/sw=000, sub/bgtz=001, sll=010, or/ori=011, and=100, slt/slti=110, beq/bne=111; zero-extended to ALUOPW.
REQ-027 All controls SHALL be fully specified in every state/opcode (no latches); inactive defaults are 0, except nRD=nWR=1.
REQ-028 retired SHALL increment by 1 on every cycle with PCWre=1, wrapping modulo 2^CNTW.
REQ-029 illegal_op SHALL set in ID on an undecoded opcode and remain set until Reset.
REQ-030 halted=1 exactly while State=HLT; PCWre=0 in HLT.

Reset
REQ-031 Reset=1 at a clock edge SHALL force State=IF, retired=0, illegal_op=0, halted=0, from any state including mid-MEM stall and HLT.
REQ-032 Reset SHALL override a simultaneous mem_ready or PCWre event; no counter increment on that edge.

Structure
REQ-033 Shared package ctrl_pkg SHALL hold the state codes, opcode constants and ALUOp codes.
REQ-034 Combinational decode SHALL live in sub-module ctrl_decode (Opcode, State, flags -> controls); state register and counter in the top.

Verification
REQ-035 Reset, add (000000) -> states IF,ID,EXE,WB,IF; RegWre=1 only in WB, ALUOp=000, retired=1.
REQ-036 lw (110001) with mem_ready low 3 cycles -> MEM held 4 cycles, nRD=0 throughout, then WB; retired=1.
REQ-037 beq (110100) zero=1 -> PCSrc=01, PCWre=1 in EXE; zero=0 -> PCSrc=00.
REQ-038 jal (111010) -> IF,ID,IF; RegWre=1, PCSrc=11 in ID; opcode 101010 -> illegal_op=1, retired increments.
REQ-039 halt (111111) -> HLT, halted=1, PCWre=0 for 10 cycles; Reset -> IF, halted=0.
REQ-040 CNTW=4, 16 j instructions -> retired wraps to 0; Reset asserted mid-MEM -> IF next cycle, retired=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multi-cycle processor control unit:
//   - state_t   : FSM state codes (these are also the values seen on State)
//   - OP_*      : opcode constants for every decoded instruction
//   - ALU_*     : ALUOp codes driven towards the ALU control
//   - instr_t   : internal instruction class produced by the opcode decoder
//   - ctrl_t    : bundle of every datapath control the decoder produces
//   - aluOpFor  : helper mapping an instruction class to its ALUOp code
// ----------------------------------------------------------------------------
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'b000,
        S_ID  = 3'b001,
        S_EXE = 3'b010,
        S_WB  = 3'b011,
        S_MEM = 3'b100,
        S_HLT = 3'b111
    } state_t;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SLTI = 6'b100111;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101;
    localparam logic [5:0] OP_BGTZ = 6'b110110;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_CMP = 3'b111;

    typedef enum logic [4:0] {
        I_ADD, I_SUB, I_ADDI, I_OR, I_AND, I_ORI, I_SLL, I_SLT, I_SLTI,
        I_SW, I_LW, I_BEQ, I_BNE, I_BGTZ, I_J, I_JR, I_JAL, I_HALT, I_BAD
    } instr_t;

    typedef struct packed {
        logic       pcWre;
        logic       irWre;
        logic       regWre;
        logic       insMemRW;
        logic       nRD;
        logic       nWR;
        logic       aluSrcA;
        logic       aluSrcB;
        logic       dbDataSrc;
        logic       wrRegDSrc;
        logic       extSel;
        logic [1:0] regDst;
        logic [1:0] pcSrc;
        logic [2:0] aluOp;
    } ctrl_t;

    // Instructions without an ALU role (jumps, halt, undecoded) fall back to add.
    function automatic logic [2:0] aluOpFor(input instr_t instr);
        case (instr)
            I_SUB, I_BGTZ:  return ALU_SUB;
            I_SLL:          return ALU_SLL;
            I_OR, I_ORI:    return ALU_OR;
            I_AND:          return ALU_AND;
            I_SLT, I_SLTI:  return ALU_SLT;
            I_BEQ, I_BNE:   return ALU_CMP;
            default:        return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ----------------------------------------------------------------------------
// ctrl_decode
// Purely combinational decoder: turns the current opcode, FSM state and ALU /
// memory flags into every datapath control plus the FSM next state.
// Ports:
//   opcode_i     opcode field of the instruction register
//   state_i      current FSM state
//   zero_i       ALU zero flag (meaningful in EXE)
//   sign_i       ALU sign flag (meaningful in EXE)
//   memReady_i   data memory ready (meaningful in MEM)
//   ctrl_o       bundle of datapath controls
//   nextState_o  state to load on the next clock edge
//   undecoded_o  opcode is not a known instruction
// ----------------------------------------------------------------------------
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic [OPW-1:0] opcode_i,
    input  state_t         state_i,
    input  logic           zero_i,
    input  logic           sign_i,
    input  logic           memReady_i,
    output ctrl_t          ctrl_o,
    output state_t         nextState_o,
    output logic           undecoded_o
);

    instr_t instr;
    logic   branchTaken;

    // Classify the opcode once so the control logic works on instruction
    // names rather than bit patterns.
    always_comb begin
        instr = I_BAD;
        case (opcode_i)
            OPW'(OP_ADD):  instr = I_ADD;
            OPW'(OP_SUB):  instr = I_SUB;
            OPW'(OP_ADDI): instr = I_ADDI;
            OPW'(OP_OR):   instr = I_OR;
            OPW'(OP_AND):  instr = I_AND;
            OPW'(OP_ORI):  instr = I_ORI;
            OPW'(OP_SLL):  instr = I_SLL;
            OPW'(OP_SLT):  instr = I_SLT;
            OPW'(OP_SLTI): instr = I_SLTI;
            OPW'(OP_SW):   instr = I_SW;
            OPW'(OP_LW):   instr = I_LW;
            OPW'(OP_BEQ):  instr = I_BEQ;
            OPW'(OP_BNE):  instr = I_BNE;
            OPW'(OP_BGTZ): instr = I_BGTZ;
            OPW'(OP_J):    instr = I_J;
            OPW'(OP_JR):   instr = I_JR;
            OPW'(OP_JAL):  instr = I_JAL;
            OPW'(OP_HALT): instr = I_HALT;
            default:       instr = I_BAD;
        endcase
    end

    assign undecoded_o = (instr == I_BAD);

    // bgtz is taken only for a strictly positive result: neither negative nor zero.
    assign branchTaken = ((instr == I_BEQ)  &&  zero_i) ||
                         ((instr == I_BNE)  && !zero_i) ||
                         ((instr == I_BGTZ) && !(sign_i || zero_i));

    // Opcode-field controls are driven from the instruction alone; the
    // state-dependent strobes (PC/IR/register/memory writes) are then layered
    // on per state so that PCWre fires exactly once, in each instruction's
    // last state.
    always_comb begin
        ctrl_o           = '0;
        ctrl_o.insMemRW  = 1'b1;
        ctrl_o.nRD       = 1'b1;
        ctrl_o.nWR       = 1'b1;
        ctrl_o.aluOp     = aluOpFor(instr);
        ctrl_o.extSel    = (instr != I_ORI);
        ctrl_o.aluSrcA   = (instr == I_SLL);
        ctrl_o.aluSrcB   = (instr == I_ADDI) || (instr == I_ORI) || (instr == I_SLTI) ||
                           (instr == I_LW)   || (instr == I_SW);
        ctrl_o.dbDataSrc = (instr == I_LW);
        ctrl_o.wrRegDSrc = (instr != I_JAL);
        case (instr)
            I_ADD, I_SUB, I_AND, I_OR, I_SLT, I_SLL: ctrl_o.regDst = 2'b10;
            I_ADDI, I_ORI, I_SLTI, I_LW:             ctrl_o.regDst = 2'b01;
            default:                                 ctrl_o.regDst = 2'b00;
        endcase
        nextState_o = S_IF;

        case (state_i)
            S_IF: begin
                ctrl_o.irWre = 1'b1;
                nextState_o  = S_ID;
            end
            S_ID: begin
                case (instr)
                    I_J, I_JAL: begin
                        ctrl_o.pcWre  = 1'b1;
                        ctrl_o.pcSrc  = 2'b11;
                        ctrl_o.regWre = (instr == I_JAL);
                        nextState_o   = S_IF;
                    end
                    I_JR: begin
                        ctrl_o.pcWre = 1'b1;
                        ctrl_o.pcSrc = 2'b10;
                        nextState_o  = S_IF;
                    end
                    I_BAD: begin
                        ctrl_o.pcWre = 1'b1;
                        nextState_o  = S_IF;
                    end
                    I_HALT:  nextState_o = S_HLT;
                    default: nextState_o = S_EXE;
                endcase
            end
            S_EXE: begin
                case (instr)
                    I_BEQ, I_BNE, I_BGTZ: begin
                        ctrl_o.pcWre = 1'b1;
                        ctrl_o.pcSrc = branchTaken ? 2'b01 : 2'b00;
                        nextState_o  = S_IF;
                    end
                    I_SW, I_LW: nextState_o = S_MEM;
                    default:    nextState_o = S_WB;
                endcase
            end
            S_MEM: begin
                ctrl_o.nRD = !(instr == I_LW);
                if (!memReady_i) begin
                    nextState_o = S_MEM;
                end else if (instr == I_SW) begin
                    ctrl_o.nWR   = 1'b0;
                    ctrl_o.pcWre = 1'b1;
                    nextState_o  = S_IF;
                end else begin
                    nextState_o = S_WB;
                end
            end
            S_WB: begin
                ctrl_o.regWre = 1'b1;
                ctrl_o.pcWre  = 1'b1;
                nextState_o   = S_IF;
            end
            S_HLT:   nextState_o = S_HLT;
            default: nextState_o = S_IF;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// multi_cycle_ctrl_fsm
// Control unit of a multi-cycle MIPS-like processor: state register, retired
// instruction counter and sticky status flags around the ctrl_decode decoder.
// Ports:
//   CLK, Reset            clock and synchronous active-high reset
//   Opcode                opcode field of the instruction register
//   zero, sign            ALU flags
//   mem_ready             data memory ready
//   State                 current state code
//   PCWre ... ExtSel      single-bit datapath controls
//   RegDst, PCSrc, ALUOp  multi-bit datapath controls
//   halted                processor stopped on halt
//   illegal_op            sticky undecoded-opcode flag
//   retired               completed instruction count (wraps)
// ----------------------------------------------------------------------------
module multi_cycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int OPW    = 6,
    parameter int ALUOPW = 3,
    parameter int CNTW   = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [OPW-1:0]    Opcode,
    input  logic              zero,
    input  logic              sign,
    input  logic              mem_ready,
    output logic [2:0]        State,
    output logic              PCWre,
    output logic              IRWre,
    output logic              RegWre,
    output logic              InsMemRW,
    output logic              nRD,
    output logic              nWR,
    output logic              ALUSrcA,
    output logic              ALUSrcB,
    output logic              DBDataSrc,
    output logic              WrRegDSrc,
    output logic              ExtSel,
    output logic [1:0]        RegDst,
    output logic [1:0]        PCSrc,
    output logic [ALUOPW-1:0] ALUOp,
    output logic              halted,
    output logic              illegal_op,
    output logic [CNTW-1:0]   retired
);

    state_t          state_q;
    state_t          state_d;
    ctrl_t           ctrl;
    logic            undecoded;
    logic [CNTW-1:0] retired_q;
    logic            illegalOp_q;
    logic            halted_q;

    ctrl_decode #(
        .OPW(OPW)
    ) uDecode (
        .opcode_i    (Opcode),
        .state_i     (state_q),
        .zero_i      (zero),
        .sign_i      (sign),
        .memReady_i  (mem_ready),
        .ctrl_o      (ctrl),
        .nextState_o (state_d),
        .undecoded_o (undecoded)
    );

    // Reset has priority over everything, so a completing instruction on the
    // reset edge is neither counted nor allowed to move the FSM. halted is
    // registered from the next state so it tracks State==HLT exactly.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q     <= S_IF;
            retired_q   <= '0;
            illegalOp_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == S_HLT);
            if (ctrl.pcWre) begin
                retired_q <= retired_q + CNTW'(1);
            end
            if ((state_q == S_ID) && undecoded) begin
                illegalOp_q <= 1'b1;
            end
        end
    end

    assign State      = state_q;
    assign PCWre      = ctrl.pcWre;
    assign IRWre      = ctrl.irWre;
    assign RegWre     = ctrl.regWre;
    assign InsMemRW   = ctrl.insMemRW;
    assign nRD        = ctrl.nRD;
    assign nWR        = ctrl.nWR;
    assign ALUSrcA    = ctrl.aluSrcA;
    assign ALUSrcB    = ctrl.aluSrcB;
    assign DBDataSrc  = ctrl.dbDataSrc;
    assign WrRegDSrc  = ctrl.wrRegDSrc;
    assign ExtSel     = ctrl.extSel;
    assign RegDst     = ctrl.regDst;
    assign PCSrc      = ctrl.pcSrc;
    assign ALUOp      = ALUOPW'(ctrl.aluOp);
    assign halted     = halted_q;
    assign illegal_op = illegalOp_q;
    assign retired    = retired_q;

endmodule
